// File: rtl/in_fsm_if.sv
// Receive-side bus bundle for in_fsm: PHY RX nibble inputs on one side,
// receive data buffer and control FIFO write ports on the other.
interface in_fsm_if #(
    parameter int SEQ_W = 11
);
    // PHY receive side
    logic             rx_dv_in;
    logic             rx_er_in;
    logic [3:0]       data_in;

    // Receive data buffer write port
    logic [7:0]       data_out;
    logic             wren_data_out;

    // Receive control FIFO write port
    logic [23:0]      ctrl_block_out;
    logic             wren_ctrl_out;

    // Status
    logic [SEQ_W-1:0] frame_seq_out;
    logic             busy_out;

    // The FSM itself: consumes PHY nibbles, produces buffer/FIFO writes
    modport slave (
        input  rx_dv_in,
        input  rx_er_in,
        input  data_in,
        output data_out,
        output wren_data_out,
        output ctrl_block_out,
        output wren_ctrl_out,
        output frame_seq_out,
        output busy_out
    );

    // The PHY/consumer side that drives nibbles and observes writes
    modport master (
        output rx_dv_in,
        output rx_er_in,
        output data_in,
        input  data_out,
        input  wren_data_out,
        input  ctrl_block_out,
        input  wren_ctrl_out,
        input  frame_seq_out,
        input  busy_out
    );
endinterface

// File: rtl/in_fsm.sv
// in_fsm: receive nibble FSM. Strips preamble/SFD from an MII-style nibble
// stream (low nibble first), assembles bytes into the receive data buffer and
// emits one {err, seq, length} control word per frame into the control FIFO.
module in_fsm #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int SEQ_W   = 11
) (
    input  logic     clk_phy,
    input  logic     reset,
    in_fsm_if.slave  bus
);

    localparam int LEN_W  = 12;
    localparam int CTRL_W = 1 + SEQ_W + LEN_W;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA_LO  = 3'd2,
        S_DATA_HI  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Registered state and outputs
    state_t             r_state;
    logic [7:0]         r_data;
    logic               r_wren_data;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_wren_ctrl;
    logic [SEQ_W-1:0]   r_seq;
    logic               r_busy;
    logic [LEN_W-1:0]   r_len;
    logic               r_err;
    logic [3:0]         r_lo;

    // Next-state values
    state_t             w_state;
    logic [7:0]         w_data;
    logic               w_wren_data;
    logic [CTRL_W-1:0]  w_ctrl;
    logic               w_wren_ctrl;
    logic [SEQ_W-1:0]   w_seq;
    logic               w_busy;
    logic [LEN_W-1:0]   w_len;
    logic               w_err;
    logic [3:0]         w_lo;

    // Frame-end request from the data states and the error bit it carries
    logic               w_end;
    logic               w_end_err;
    logic [SEQ_W-1:0]   w_seq_inc;

    // Sequence number of the frame being closed; wraps naturally at 2^SEQ_W
    assign w_seq_inc = r_seq + 1'b1;

    // State register and registered outputs; async clear discards any frame
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_wren_data <= 1'b0;
            r_ctrl      <= '0;
            r_wren_ctrl <= 1'b0;
            r_seq       <= '0;
            r_busy      <= 1'b0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_lo        <= '0;
        end else begin
            r_state     <= w_state;
            r_data      <= w_data;
            r_wren_data <= w_wren_data;
            r_ctrl      <= w_ctrl;
            r_wren_ctrl <= w_wren_ctrl;
            r_seq       <= w_seq;
            r_busy      <= w_busy;
            r_len       <= w_len;
            r_err       <= w_err;
            r_lo        <= w_lo;
        end
    end

    // Next-state and output decode; strobes default low, everything else holds
    always_comb begin
        w_state     = r_state;
        w_data      = r_data;
        w_wren_data = 1'b0;
        w_ctrl      = r_ctrl;
        w_wren_ctrl = 1'b0;
        w_seq       = r_seq;
        w_busy      = r_busy;
        w_len       = r_len;
        w_err       = r_err;
        w_lo        = r_lo;
        w_end       = 1'b0;
        w_end_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Only a preamble nibble starts a frame; other traffic is ignored
                if (bus.rx_dv_in && (bus.data_in == NIB_PRE)) begin
                    w_state = S_PREAMBLE;
                end
            end

            S_PREAMBLE: begin
                if (!bus.rx_dv_in) begin
                    w_state = S_IDLE;
                end else if (bus.data_in == NIB_PRE) begin
                    w_state = S_PREAMBLE;
                end else if (bus.data_in == NIB_SFD) begin
                    w_state = S_DATA_LO;
                    w_busy  = 1'b1;
                    w_len   = '0;
                    w_err   = 1'b0;
                end else begin
                    // Corrupt preamble: abandon silently
                    w_state = S_IDLE;
                end
            end

            S_DATA_LO: begin
                if (bus.rx_dv_in) begin
                    w_lo    = bus.data_in;
                    w_state = S_DATA_HI;
                    if (bus.rx_er_in) begin
                        w_err = 1'b1;
                    end
                end else begin
                    // Clean end on a byte boundary; runts are flagged here
                    w_end     = 1'b1;
                    w_end_err = r_err | (r_len < MIN_LEN_L);
                end
            end

            S_DATA_HI: begin
                if (bus.rx_dv_in) begin
                    w_state = S_DATA_LO;
                    if (bus.rx_er_in) begin
                        w_err = 1'b1;
                    end
                    if (r_len < MAX_LEN_L) begin
                        w_data      = {bus.data_in, r_lo};
                        w_wren_data = 1'b1;
                        w_len       = r_len + 1'b1;
                    end else begin
                        // Oversize: drop the byte, keep length pinned at the cap
                        w_err = 1'b1;
                    end
                end else begin
                    // Dribble nibble: half a byte is never written
                    w_end     = 1'b1;
                    w_end_err = 1'b1;
                end
            end

            S_DONE: begin
                // Dead cycle while the control word is written; inputs ignored
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Frame close: the control word and status land in the DONE cycle
        if (w_end) begin
            w_state     = S_DONE;
            w_ctrl      = {w_end_err, w_seq_inc, r_len};
            w_wren_ctrl = 1'b1;
            w_seq       = w_seq_inc;
            w_busy      = 1'b0;
            w_len       = '0;
            w_err       = 1'b0;
        end
    end

    assign bus.data_out       = r_data;
    assign bus.wren_data_out  = r_wren_data;
    assign bus.ctrl_block_out = r_ctrl;
    assign bus.wren_ctrl_out  = r_wren_ctrl;
    assign bus.frame_seq_out  = r_seq;
    assign bus.busy_out       = r_busy;

    // Byte and control writes share no cycle, so a single downstream arbiter is not needed
    always @(posedge clk_phy) begin
        if (reset) begin
            assert (!(r_wren_data && r_wren_ctrl))
                else $error("in_fsm: data and ctrl strobes overlap");
            assert (r_len <= MAX_LEN_L)
                else $error("in_fsm: length exceeded MAX_LEN");
        end
    end

endmodule

// File: tb/tb_in_fsm.sv
// Bench for in_fsm: drives nibble frames, pushes expected bytes and control
// words into queues as stimulus is applied, and pops/compares on each strobe.
module tb_in_fsm;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;
    localparam int SEQ_W   = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    in_fsm_if #(.SEQ_W(SEQ_W)) bus ();

    in_fsm #(
        .MAX_LEN (MAX_LEN),
        .MIN_LEN (MIN_LEN),
        .SEQ_W   (SEQ_W)
    ) dut (
        .clk_phy (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]       exp_data_q[$];
    logic [23:0]      exp_ctrl_q[$];
    logic [SEQ_W-1:0] exp_seq = '0;

    int n_wr_data   = 0;
    int n_wr_ctrl   = 0;
    int exp_wr_data = 0;
    int exp_wr_ctrl = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: one line per observed write
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wren_data_out || bus.wren_ctrl_out) begin
                check_eq("wren_exclusive", 32'(bus.wren_data_out & bus.wren_ctrl_out), 32'd0);
            end
            if (bus.wren_data_out) begin
                n_wr_data++;
                if (exp_data_q.size() > 0) begin
                    logic [7:0] eb;
                    eb = exp_data_q.pop_front();
                    check_eq("data_out", 32'(bus.data_out), 32'(eb));
                end
            end
            if (bus.wren_ctrl_out) begin
                n_wr_ctrl++;
                if (exp_ctrl_q.size() > 0) begin
                    logic [23:0] ec;
                    ec = exp_ctrl_q.pop_front();
                    $display("ctrl write: %06h (expect %06h)", bus.ctrl_block_out, ec);
                    check_eq("ctrl_block_out", 32'(bus.ctrl_block_out), 32'(ec));
                    check_eq("frame_seq_at_ctrl", 32'(bus.frame_seq_out), 32'(ec[22:12]));
                    check_eq("busy_at_ctrl", 32'(bus.busy_out), 32'd0);
                end
            end
        end
    end

    task automatic nib(input logic dv, input logic er, input logic [3:0] d);
        @(negedge clk);
        bus.rx_dv_in = dv;
        bus.rx_er_in = er;
        bus.data_in  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) nib(1'b0, 1'b0, 4'h0);
    endtask

    function automatic logic [7:0] byte_val(input int k);
        logic [7:0] tbl [4];
        tbl = '{8'h10, 8'hAB, 8'hCD, 8'hEF};
        return tbl[k % 4] ^ 8'(k / 4);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data_out"},  32'(bus.data_out),       32'd0);
        check_eq({tag, "_wren_data"}, 32'(bus.wren_data_out),  32'd0);
        check_eq({tag, "_ctrl"},      32'(bus.ctrl_block_out), 32'd0);
        check_eq({tag, "_wren_ctrl"}, 32'(bus.wren_ctrl_out),  32'd0);
        check_eq({tag, "_seq"},       32'(bus.frame_seq_out),  32'd0);
        check_eq({tag, "_busy"},      32'(bus.busy_out),       32'd0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.rx_dv_in = 1'b0;
        bus.rx_er_in = 1'b0;
        bus.data_in  = 4'h0;
        repeat (cycles) @(negedge clk);
        check_reset_outputs("reset");
        exp_seq = '0;
        rst_n   = 1'b1;
        idle(2);
    endtask

    task automatic end_of_frame_checks(input string tag);
        check_eq({tag, "_bytes_left"}, 32'(exp_data_q.size()), 32'd0);
        check_eq({tag, "_ctrl_left"},  32'(exp_ctrl_q.size()), 32'd0);
        check_eq({tag, "_n_wr_data"},  32'(n_wr_data),         32'(exp_wr_data));
        check_eq({tag, "_n_wr_ctrl"},  32'(n_wr_ctrl),         32'(exp_wr_ctrl));
        check_eq({tag, "_seq_out"},    32'(bus.frame_seq_out), 32'(exp_seq));
        check_eq({tag, "_busy_idle"},  32'(bus.busy_out),      32'd0);
    endtask

    // Full frame: 15 preamble nibbles, SFD, n_bytes bytes, optional dribble nibble
    task automatic send_frame(input string tag, input int n_bytes, input int er_byte, input bit dribble);
        logic [7:0]  b;
        logic [11:0] len;
        logic        err;
        repeat (15) nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'hD);
        for (int k = 0; k < n_bytes; k++) begin
            b = byte_val(k);
            nib(1'b1, (k == er_byte), b[3:0]);
            nib(1'b1, 1'b0, b[7:4]);
            if (k < MAX_LEN) begin
                exp_data_q.push_back(b);
                exp_wr_data++;
            end
            if (k == 0) check_eq({tag, "_busy_mid"}, 32'(bus.busy_out), 32'd1);
        end
        if (dribble) nib(1'b1, 1'b0, 4'h3);
        len = (n_bytes > MAX_LEN) ? 12'(MAX_LEN) : 12'(n_bytes);
        err = (er_byte >= 0) || (n_bytes > MAX_LEN) || dribble || (len < 12'(MIN_LEN));
        exp_seq = exp_seq + 1'b1;
        exp_ctrl_q.push_back({err, exp_seq, len});
        exp_wr_ctrl++;
        idle(12);
        end_of_frame_checks(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_dv_in = 1'b0;
        bus.rx_er_in = 1'b0;
        bus.data_in  = 4'h0;

        // Reset held 6 cycles
        do_reset(6);

        // Nominal 64-byte frame, then runt, rx_er, oversize, dribble, zero-length
        send_frame("f64",      64,   -1, 1'b0);
        send_frame("runt10",   10,   -1, 1'b0);
        send_frame("rxer64",   64,   17, 1'b0);
        send_frame("over1600", 1600, -1, 1'b0);
        send_frame("dribble",  64,   -1, 1'b1);
        send_frame("zero",     0,    -1, 1'b0);

        // Corrupt preamble then non-preamble traffic: no writes at all
        repeat (4) nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'h3);
        nib(1'b1, 1'b0, 4'hD);
        nib(1'b1, 1'b0, 4'hA);
        nib(1'b1, 1'b0, 4'hD);
        idle(8);
        end_of_frame_checks("bad_pre");

        // Runt right after a fresh reset: ctrl word is the literal 80100A
        do_reset(3);
        send_frame("runt_fresh", 10, -1, 1'b0);
        check_eq("runt_fresh_seq1", 32'(bus.frame_seq_out), 32'd1);

        // Reset mid-frame: bytes already written are kept, no ctrl write follows
        repeat (15) nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'hD);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] bb;
            bb = byte_val(k);
            nib(1'b1, 1'b0, bb[3:0]);
            nib(1'b1, 1'b0, bb[7:4]);
            exp_data_q.push_back(bb);
            exp_wr_data++;
        end
        nib(1'b1, 1'b0, 4'h7);
        @(negedge clk);
        check_eq("pre_abort_busy", 32'(bus.busy_out), 32'd1);
        do_reset(4);
        idle(10);
        end_of_frame_checks("abort");

        // Recovery: next frame starts again at sequence 1
        send_frame("after_abort", 64, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
